// File: rtl/store_rmw_ctrl_pkg.sv
// Shared types for the store read-modify-write controller: op encodings,
// FSM state enum, default memory timeout and the misalignment predicate.
package store_ctrl_pkg;

    localparam logic [1:0] STOREOP_SB = 2'b00;
    localparam logic [1:0] STOREOP_SH = 2'b01;
    localparam logic [1:0] STOREOP_SW = 2'b10;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Op 11 behaves as a word store, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] op, input logic [1:0] lane);
        if (op == STOREOP_SB) return 1'b0;
        if (op == STOREOP_SH) return lane[0];
        return lane != 2'b00;
    endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Core store request channel and word-wide data memory port.
// Request: a store transfers when st_valid & st_ready are both high on a rising
// edge; the requester holds valid and payload stable until then. Memory: a phase
// completes on the edge where mem_req & mem_ack are both high; mem_ack is ignored
// while mem_req is low.
interface store_req_if;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_op;
    logic        done;
    logic        err;

    modport master (output st_valid, st_addr, st_data, st_op,
                    input  st_ready, done, err);
    modport slave  (input  st_valid, st_addr, st_data, st_op,
                    output st_ready, done, err);
endinterface

interface mem_port_if;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/store_rmw_ctrl_merge.sv
// Combinational lane merge: overlays the new byte/halfword onto the old word.
module store_merge
    import store_ctrl_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  lane,
    input  logic [1:0]  op,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_word;
        case (op)
            STOREOP_SB: begin
                case (lane)
                    2'd0:    merged[7:0]   = new_data[7:0];
                    2'd1:    merged[15:8]  = new_data[7:0];
                    2'd2:    merged[23:16] = new_data[7:0];
                    default: merged[31:24] = new_data[7:0];
                endcase
            end
            STOREOP_SH: begin
                if (lane[1]) merged[31:16] = new_data[15:0];
                else         merged[15:0]  = new_data[15:0];
            end
            default: merged = new_data;
        endcase
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: word stores write directly, sub-word stores read-merge-write.
// Optional STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW with err, no memory phase.
module store_rmw_ctrl
    import store_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    store_req_if.slave st,
    mem_port_if.master mem,
    output state_e     dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic          err_d;
    logic [CW-1:0] cnt_q;
    logic          accept, trap, phase_timeout;
    logic [31:0]   addr_q, data_q, wdata_q, merged;
    logic [1:0]    op_q;
    logic          ready_q, done_q, err_q, req_q, we_q;

    assign accept = st.st_valid & ready_q;

`ifdef STORE_MISALIGN_TRAP_EN
    assign trap = is_misaligned(st.st_op, st.st_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Counter holds the wait cycles already spent; the last allowed one aborts.
    assign phase_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (trap) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = st.st_op[1] ? WR : RD;
                    end
                end
            end
            RD, WR: begin
                if (mem.mem_ack) begin
                    state_d = (state_q == RD) ? WR : RESP;
                end else if (phase_timeout) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    store_merge u_merge (
        .old_word (mem.mem_rdata),
        .new_data (data_q),
        .lane     (addr_q[1:0]),
        .op       (op_q),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            op_q    <= STOREOP_SB;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
            req_q   <= (state_d == RD) || (state_d == WR);
            we_q    <= (state_d == WR);
            done_q  <= (state_d == RESP);
            err_q   <= err_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (req_q && !mem.mem_ack && (TIMEOUT_CYCLES != 0))
                cnt_q <= cnt_q + CW'(1);
            if (accept) begin
                addr_q  <= st.st_addr;
                data_q  <= st.st_data;
                op_q    <= st.st_op;
                wdata_q <= st.st_data;
            end
            // Read data is merged straight into the write register on the read ack.
            if ((state_q == RD) && mem.mem_ack)
                wdata_q <= merged;
        end
    end

    assign st.st_ready    = ready_q;
    assign st.done        = done_q;
    assign st.err         = err_q;
    assign mem.mem_req    = req_q;
    assign mem.mem_we     = we_q;
    assign mem.mem_addr   = addr_q[31:2];
    assign mem.mem_wdata  = wdata_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Self-checking bench for store_rmw_ctrl with a latency-programmable memory responder.
module tb_store_rmw_ctrl;
  import store_ctrl_pkg::*;

  localparam int W  = 73;
  localparam int TO = 4;

  logic   clk = 1'b0;
  logic   rst_n = 1'b1;
  state_e dbg_state;

  store_req_if st();
  mem_port_if  m();

  store_rmw_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st        (st),
    .mem       (m),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard and observation state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs, exp_v;
  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  bit ack_never = 0;
  bit spurious = 0;
  logic [31:0] mem_word = '0;
  int acc_cyc = 0, prev_acc = 0, extra_acc = 0;
  logic saw_rd, saw_we, o_err;
  logic [29:0] o_addr;
  logic [31:0] o_wdata;
  int o_lat;

  // memory responder: ack in cycle ack_delay of each phase
  initial begin
    int pc = 0;
    logic prev_req = 0, prev_we = 0, prev_ack = 0;
    m.mem_ack = 1'b0;
    m.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (m.mem_req) begin
        if (!prev_req || prev_we != m.mem_we || prev_ack) pc = 0;
        else pc++;
        m.mem_ack = !ack_never && (pc == ack_delay);
      end else begin
        pc = 0;
        m.mem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      m.mem_rdata = mem_word;
      prev_req = m.mem_req;
      prev_we  = m.mem_we;
      prev_ack = m.mem_ack;
    end
  end

  function automatic logic [W-1:0] pack_res(logic e, logic r, logic w, logic [29:0] a,
                                            logic [31:0] d, int lat);
    return {e, r, w, (w ? a : 30'h0), (w ? d : 32'h0), 8'(lat)};
  endfunction

  function automatic logic [31:0] model_merge(logic [1:0] op, logic [31:0] old_w,
                                              logic [31:0] data, logic [1:0] lane);
    logic [31:0] mask, sh;
    if (op == 2'b00) begin
      mask = 32'hFF << (8 * lane);
      sh   = data << (8 * lane);
    end else if (op == 2'b01) begin
      mask = 32'hFFFF << (16 * lane[1]);
      sh   = data << (16 * lane[1]);
    end else begin
      return data;
    end
    return (old_w & ~mask) | (sh & mask);
  endfunction

  // driver tasks
  task automatic do_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input bit hold);
    bit ok = 0;
    @(posedge clk); #1;
    st.st_valid = 1'b1; st.st_op = op; st.st_addr = addr; st.st_data = data;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = st.st_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_wait: st_ready=0 required 1 within 50 cycles");
    end
    prev_acc = acc_cyc; acc_cyc = cyc;
    saw_rd = 0; saw_we = 0; extra_acc = 0; o_addr = '0; o_wdata = '0;
    if (!hold) begin
      @(posedge clk); #1;
      st.st_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (st.st_valid && st.st_ready) extra_acc++;
      if (m.mem_req && !m.mem_we) saw_rd = 1;
      if (m.mem_req && m.mem_we) begin
        saw_we = 1; o_addr = m.mem_addr; o_wdata = m.mem_wdata;
      end
      if (st.done) begin
        got = 1; o_err = st.err; o_lat = cyc - acc_cyc;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_wait: done=0 required 1 within 60 cycles");
      o_err = 1'bx;
    end
    obs = pack_res(o_err, saw_rd, saw_we, o_addr, o_wdata, o_lat);
  endtask

  task automatic run_store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                           input bit hold, input int d, input bit never, input logic [31:0] word);
    ack_delay = d; ack_never = never; mem_word = word;
    do_store(op, addr, data, hold);
    wait_done();
  endtask

  // scenarios
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #10;
    checks++;
    if ({st.st_ready, st.done, st.err, m.mem_req, m.mem_we, m.mem_addr, m.mem_wdata} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0})
      begin errors++; $display("FAIL reset_outputs: rdy=%b done=%b err=%b req=%b we=%b addr=%h wd=%h required 1 0 0 0 0 0 0",
        st.st_ready, st.done, st.err, m.mem_req, m.mem_we, m.mem_addr, m.mem_wdata); end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d required IDLE", dbg_state); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sb_zero_wait();
    exp_q.push_back(pack_res(0, 1, 1, 30'h40, 32'h11AB3344, 3));
    run_store(STOREOP_SB, 32'h102, 32'hAB, 0, 0, 0, 32'h11223344);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sb_zero_wait: got %h required %h", obs, exp_v); end
    @(negedge clk);
    checks++;
    if ({st.done, st.st_ready} !== 2'b01) begin errors++; $display("FAIL done_pulse: done/ready=%b required 01", {st.done, st.st_ready}); end
  endtask

  task automatic test_sh_wait();
    exp_q.push_back(pack_res(0, 1, 1, 30'h1, 32'hBEEFAAAA, 5));
    run_store(STOREOP_SH, 32'h006, 32'hBEEF, 0, 1, 0, 32'hAAAAAAAA);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sh_wait: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_sw_hold();
    exp_q.push_back(pack_res(0, 0, 1, 30'h8, 32'hDEADBEEF, 2));
    run_store(STOREOP_SW, 32'h20, 32'hDEADBEEF, 1, 0, 0, 32'h0);
    st.st_valid = 1'b0;
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sw_hold: got %h required %h", obs, exp_v); end
    checks++;
    if (extra_acc !== 0) begin errors++; $display("FAIL sw_reaccept: got %0d extra accepts required 0", extra_acc); end
  endtask

  task automatic test_op11();
    exp_q.push_back(pack_res(0, 0, 1, 30'h11, 32'h13579BDF, 2));
    run_store(2'b11, 32'h44, 32'h13579BDF, 0, 0, 0, 32'hFFFFFFFF);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL op11_word: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_timeout();
    exp_q.push_back(pack_res(1, 1, 0, 30'h0, 32'h0, TO + 1));
    run_store(STOREOP_SB, 32'h104, 32'h55, 0, 0, 1, 32'h12345678);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL timeout_rd: got %h required %h", obs, exp_v); end
    exp_q.push_back(pack_res(1, 0, 1, 30'hC, 32'hCAFEBABE, TO + 1));
    run_store(STOREOP_SW, 32'h30, 32'hCAFEBABE, 0, 0, 1, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL timeout_wr: got %h required %h", obs, exp_v); end
    // ack on the last allowed cycle completes normally
    exp_q.push_back(pack_res(0, 1, 1, 30'h40, 32'h77020304, 3 + 2 * (TO - 1)));
    run_store(STOREOP_SB, 32'h103, 32'h77, 0, TO - 1, 0, 32'h01020304);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL ack_at_limit: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_misalign();
`ifdef STORE_MISALIGN_TRAP_EN
    exp_q.push_back(pack_res(1, 0, 0, 30'h0, 32'h0, 1));
`else
    exp_q.push_back(pack_res(0, 1, 1, 30'h0, 32'hCAFE1234, 3));
`endif
    run_store(STOREOP_SH, 32'h001, 32'h1234, 0, 0, 0, 32'hCAFEF00D);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL sh_misalign: got %h required %h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(pack_res(0, 0, 1, 30'h4, 32'h11111111, 2));
    exp_q.push_back(pack_res(0, 0, 1, 30'h5, 32'h22222222, 2));
    run_store(STOREOP_SW, 32'h10, 32'h11111111, 0, 0, 0, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_sw0: got %h required %h", obs, exp_v); end
    run_store(STOREOP_SW, 32'h14, 32'h22222222, 0, 0, 0, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_sw1: got %h required %h", obs, exp_v); end
    checks++;
    if (acc_cyc - prev_acc !== 3) begin errors++; $display("FAIL b2b_sw_gap: got %0d required 3", acc_cyc - prev_acc); end
    exp_q.push_back(pack_res(0, 1, 1, 30'h8, 32'h00005A00, 3));
    exp_q.push_back(pack_res(0, 1, 1, 30'h8, 32'h9876FFFF, 3));
    run_store(STOREOP_SB, 32'h21, 32'h5A, 0, 0, 0, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_sb: got %h required %h", obs, exp_v); end
    run_store(STOREOP_SH, 32'h22, 32'h9876, 0, 0, 0, 32'hFFFFFFFF);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_sh: got %h required %h", obs, exp_v); end
    checks++;
    if (acc_cyc - prev_acc !== 4) begin errors++; $display("FAIL b2b_rmw_gap: got %0d required 4", acc_cyc - prev_acc); end
  endtask

  task automatic test_random();
    spurious = 1;
    for (int n = 0; n < 10; n++) begin
      logic [1:0]  op   = 2'($urandom_range(0, 2));
      logic [1:0]  lane = 2'($urandom_range(0, 3));
      logic [31:0] data = $urandom;
      logic [31:0] word = $urandom;
      logic [31:0] addr;
      int d = $urandom_range(0, 2);
      if (op == STOREOP_SH) lane[0] = 1'b0;
      if (op == STOREOP_SW) lane = 2'b00;
      addr = {22'h0, 8'($urandom_range(0, 255)), lane};
      exp_q.push_back(pack_res(0, op != STOREOP_SW, 1, addr[31:2], model_merge(op, word, data, lane),
                               (op == STOREOP_SW) ? 2 + d : 3 + 2 * d));
      run_store(op, addr, data, 0, d, 0, word);
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL random_%0d op=%0d: got %h required %h", n, op, obs, exp_v); end
    end
    spurious = 0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    bit saw_done = 0;
    ack_delay = 2; ack_never = 0; mem_word = 32'h0;
    do_store(STOREOP_SB, 32'h200, 32'h99, 0);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = m.mem_req && m.mem_we;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach_wr: mem_we=0 required 1"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m.mem_req, m.mem_we} !== 2'b00) begin errors++; $display("FAIL reset_async_drop: req/we=%b required 00", {m.mem_req, m.mem_we}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (st.st_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b required 1", st.st_ready); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (st.done) saw_done = 1;
    end
    checks++;
    if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done: saw done=1 required 0"); end
    exp_q.push_back(pack_res(0, 0, 1, 30'h50, 32'hA5A5A5A5, 2));
    run_store(STOREOP_SW, 32'h140, 32'hA5A5A5A5, 0, 0, 0, 32'h0);
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_mid_next_sw: got %h required %h", obs, exp_v); end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    st.st_valid = 1'b0; st.st_addr = '0; st.st_data = '0; st.st_op = 2'b00;
    test_reset();
    test_sb_zero_wait();
    test_sh_wait();
    test_sw_hold();
    test_op11();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
